// File: rtl/dircc_processing_mem_msg_reader_if.sv
// Bundle of the command, memory (s2) and Avalon-ST source signals of the
// processing-memory message reader.
//   master : the reader itself (accepts commands, drives memory, sources ST)
//   slave  : the surroundings (command issuer, memory, ST sink)
// Signals:
//   cmd_valid/cmd_ready/cmd_addr/cmd_len          command handshake
//   mem_address/chipselect/write/byteenable/clken  memory s2 request
//   mem_readdata                                   memory s2 read data
//   src_valid/src_ready/src_data/src_sop/src_eop   Avalon-ST source
//   busy/done                                      status
interface dircc_processing_mem_msg_reader_if #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LEN_W  = 10
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;

    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_write;
    logic [1:0]        mem_byteenable;
    logic              mem_clken;
    logic [DATA_W-1:0] mem_readdata;

    logic              src_valid;
    logic              src_ready;
    logic [DATA_W-1:0] src_data;
    logic              src_sop;
    logic              src_eop;

    logic              busy;
    logic              done;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len, mem_readdata, src_ready,
        output cmd_ready, mem_address, mem_chipselect, mem_write,
               mem_byteenable, mem_clken, src_valid, src_data, src_sop,
               src_eop, busy, done
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len, mem_readdata, src_ready,
        input  cmd_ready, mem_address, mem_chipselect, mem_write,
               mem_byteenable, mem_clken, src_valid, src_data, src_sop,
               src_eop, busy, done
    );
endinterface

// File: rtl/dircc_processing_mem_msg_reader.sv
// Transmit-side fetch engine: takes a {base address, length} command, reads
// that many halfwords from the 16-bit s2 port of the processing memory and
// streams them out of an Avalon-ST source framed with sop/eop.
// Ports:
//   clk   : single clock, shared with the memory
//   reset : asynchronous, active-high
//   bus   : master modport of dircc_processing_mem_msg_reader_if
//           (command handshake, memory s2 request/readdata, ST source,
//            busy/done status)
module dircc_processing_mem_msg_reader #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LEN_W  = 10
) (
    input  logic clk,
    input  logic reset,
    dircc_processing_mem_msg_reader_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  remaining_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  out_cnt_q;
    logic              inflight_q;
    logic              done_q, done_d;

    logic [DATA_W-1:0] fifo_mem [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        fifo_count_q;

    logic cmd_ready;
    logic cmd_fire;
    logic issue;
    logic fifo_empty;
    logic src_valid;
    logic src_eop;
    logic beat_fire;
    logic push;
    logic pop;

    assign fifo_empty = (fifo_count_q == 2'd0);
    assign cmd_fire   = bus.cmd_valid && cmd_ready;

    // Credit rule: FIFO occupancy plus the read in flight never exceeds 2.
    assign issue = (state_q == S_FETCH) && (remaining_q != '0) &&
                   ((fifo_count_q + {1'b0, inflight_q}) < 2'd2);

    // Read data arriving into an empty FIFO is presented directly, which
    // gives the first beat one cycle after the first read issue.
    assign src_valid = !fifo_empty || inflight_q;
    assign beat_fire = src_valid && bus.src_ready;
    assign push      = inflight_q && !(fifo_empty && bus.src_ready);
    assign pop       = !fifo_empty && bus.src_ready;
    assign src_eop   = src_valid && (out_cnt_q == len_q - LEN_W'(1));

    always_comb begin
        state_d   = state_q;
        done_d    = 1'b0;
        cmd_ready = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cmd_ready = !reset;
                if (cmd_fire) begin
                    if (bus.cmd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                if (issue && remaining_q == LEN_W'(1)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // eop can only be accepted once the FIFO holds nothing else.
                if (beat_fire && src_eop) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            remaining_q  <= '0;
            len_q        <= '0;
            out_cnt_q    <= '0;
            inflight_q   <= 1'b0;
            done_q       <= 1'b0;
            fifo_mem[0]  <= '0;
            fifo_mem[1]  <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            fifo_count_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            inflight_q <= issue;

            if (cmd_fire) begin
                addr_q      <= bus.cmd_addr;
                remaining_q <= bus.cmd_len;
                len_q       <= bus.cmd_len;
                out_cnt_q   <= '0;
            end else begin
                if (issue) begin
                    addr_q      <= addr_q + ADDR_W'(1);
                    remaining_q <= remaining_q - LEN_W'(1);
                end
                if (beat_fire) begin
                    out_cnt_q <= out_cnt_q + LEN_W'(1);
                end
            end

            if (push) begin
                fifo_mem[wr_ptr_q] <= bus.mem_readdata;
                wr_ptr_q           <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            unique case ({push, pop})
                2'b10:   fifo_count_q <= fifo_count_q + 2'd1;
                2'b01:   fifo_count_q <= fifo_count_q - 2'd1;
                default: fifo_count_q <= fifo_count_q;
            endcase
        end
    end

    assign bus.cmd_ready      = cmd_ready;
    assign bus.mem_address    = addr_q;
    assign bus.mem_chipselect = issue;
    assign bus.mem_write      = 1'b0;
    assign bus.mem_byteenable = 2'b11;
    assign bus.mem_clken      = 1'b1;

    assign bus.src_valid = src_valid;
    assign bus.src_data  = !fifo_empty ? fifo_mem[rd_ptr_q] :
                           (inflight_q ? bus.mem_readdata : '0);
    assign bus.src_sop   = src_valid && (out_cnt_q == '0);
    assign bus.src_eop   = src_eop;

    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = done_q;

endmodule

// File: tb/tb_dircc_processing_mem_msg_reader.sv
module tb_dircc_processing_mem_msg_reader;

    typedef struct {
        logic [15:0] data;
        logic        sop;
        logic        eop;
    } beat_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;

    dircc_processing_mem_msg_reader_if #(.ADDR_W(14), .DATA_W(16), .LEN_W(10)) bus ();

    dircc_processing_mem_msg_reader #(.ADDR_W(14), .DATA_W(16), .LEN_W(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] mem [16384];

    always @(posedge clk) begin
        if (bus.mem_chipselect) bus.mem_readdata <= mem[bus.mem_address];
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // scoreboard and per-message statistics
    beat_t       exp_q[$];
    logic [13:0] cs_addr_q[$];
    int          done_cyc_q[$];
    int          cs_count, valid_count, beats, done_count;
    int          first_cs, first_valid, last_beat;
    logic        stall_pending = 1'b0;
    beat_t       held;
    logic        ready_mode = 1'b0;

    initial begin
        int phase = 0;
        bus.src_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode) begin
                bus.src_ready = (phase == 0);
                phase = (phase == 2) ? 0 : phase + 1;
            end else begin
                bus.src_ready = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.mem_chipselect) begin
                cs_count++;
                cs_addr_q.push_back(bus.mem_address);
                if (first_cs < 0) first_cs = cyc;
            end
            if (stall_pending) begin
                check("stall_valid_held", bus.src_valid, 1);
                check("stall_data_stable", bus.src_data, held.data);
                check("stall_sop_stable", bus.src_sop, held.sop);
                check("stall_eop_stable", bus.src_eop, held.eop);
                stall_pending = 1'b0;
            end
            if (bus.src_valid) begin
                valid_count++;
                if (first_valid < 0) first_valid = cyc;
                if (bus.src_ready) begin
                    check("sb_has_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        beat_t e;
                        e = exp_q.pop_front();
                        check("beat_data", bus.src_data, e.data);
                        check("beat_sop", bus.src_sop, e.sop);
                        check("beat_eop", bus.src_eop, e.eop);
                    end
                    beats++;
                    last_beat = cyc;
                end else begin
                    stall_pending = 1'b1;
                    held.data = bus.src_data;
                    held.sop  = bus.src_sop;
                    held.eop  = bus.src_eop;
                end
            end
            if (bus.done) begin
                done_count++;
                done_cyc_q.push_back(cyc);
            end
        end
    end

    task automatic clear_stats();
        cs_count = 0; valid_count = 0; beats = 0; done_count = 0;
        first_cs = -1; first_valid = -1; last_beat = -1;
        cs_addr_q.delete();
        done_cyc_q.delete();
    endtask

    task automatic expect_msg(input logic [13:0] addr, input int len);
        for (int i = 0; i < len; i++) begin
            beat_t b;
            logic [13:0] a;
            a = addr + 14'(i);
            b.data = mem[a];
            b.sop  = (i == 0);
            b.eop  = (i == len - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic issue_cmd(input logic [13:0] addr, input int len, output int acc);
        expect_msg(addr, len);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = addr;
        bus.cmd_len   = 10'(len);
        acc = -1;
        for (int n = 0; n < 50 && acc < 0; n++) begin
            @(negedge clk);
            if (bus.cmd_ready) acc = cyc;
        end
        check("cmd_accepted", acc >= 0, 1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        if (len > 0) check("busy_after_accept", bus.busy, 1);
    endtask

    task automatic wait_done(input int target);
        for (int n = 0; n < 300 && done_count < target; n++) @(posedge clk);
        repeat (3) @(posedge clk);
        check("done_count", done_count, target);
        check("sb_empty", exp_q.size(), 0);
        check("busy_idle", bus.busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc2;
        int pre;
        for (int i = 0; i < 16384; i++) mem[i] = 16'($urandom);
        for (int i = 0; i < 4; i++) mem[14'h100 + i] = 16'hA0A0 + 16'(i);
        clear_stats();
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        reset = 1'b1;
        #2;
        check("rst_cmd_ready", bus.cmd_ready, 0);
        check("rst_chipselect", bus.mem_chipselect, 0);
        check("rst_mem_address", bus.mem_address, 0);
        check("rst_src_valid", bus.src_valid, 0);
        check("rst_src_data", bus.src_data, 0);
        check("rst_busy_done", {bus.busy, bus.done, bus.src_sop, bus.src_eop}, 0);
        check("const_mem_ctrl", {bus.mem_write, bus.mem_byteenable, bus.mem_clken}, 4'b0111);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("idle_cmd_ready", bus.cmd_ready, 1);

        // 1: basic message, full throughput
        clear_stats();
        issue_cmd(14'h100, 4, acc);
        wait_done(1);
        check("t1_first_issue_lat", first_cs - acc, 1);
        check("t1_first_valid_lat", first_valid - acc, 2);
        check("t1_consecutive", last_beat - first_valid, 3);
        check("t1_done_after_eop", done_cyc_q.size() > 0 ? done_cyc_q[0] - last_beat : -1, 1);
        check("t1_cs_pulses", cs_count, 4);
        check("t1_beats", beats, 4);

        // 2: backpressure 1,0,0 pattern
        clear_stats();
        ready_mode = 1'b1;
        issue_cmd(14'h100, 4, acc);
        wait_done(1);
        ready_mode = 1'b0;
        check("t2_cs_pulses", cs_count, 4);
        check("t2_beats", beats, 4);

        // 3: address wrap
        clear_stats();
        issue_cmd(14'h3FFE, 4, acc);
        wait_done(1);
        check("t3_cs_count", cs_addr_q.size(), 4);
        for (int i = 0; i < 4 && i < cs_addr_q.size(); i++) begin
            logic [13:0] ea;
            ea = 14'h3FFE + 14'(i);
            check("t3_addr_seq", cs_addr_q[i], ea);
        end

        // 4: empty command, then single-beat message
        clear_stats();
        issue_cmd(14'h0200, 0, acc);
        wait_done(1);
        check("t4_len0_cs", cs_count, 0);
        check("t4_len0_valid", valid_count, 0);
        clear_stats();
        issue_cmd(14'h0203, 1, acc);
        wait_done(1);
        check("t4_len1_beats", beats, 1);

        // 5: reset after two of six beats
        clear_stats();
        issue_cmd(14'h0300, 6, acc);
        for (int n = 0; n < 50 && beats < 2; n++) @(posedge clk);
        check("t5_two_beats", beats, 2);
        #2 reset = 1'b1;
        #1;
        check("t5_rst_valid", bus.src_valid, 0);
        check("t5_rst_chipselect", bus.mem_chipselect, 0);
        check("t5_rst_mem_address", bus.mem_address, 0);
        check("t5_rst_status", {bus.busy, bus.done, bus.cmd_ready, bus.src_sop, bus.src_eop}, 0);
        check("t5_rst_data", bus.src_data, 0);
        exp_q.delete();
        stall_pending = 1'b0;
        pre = done_count;
        check("t5_no_done_abort", pre, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        clear_stats();
        issue_cmd(14'h0400, 3, acc);
        wait_done(1);
        check("t5_restart_beats", beats, 3);

        // 6: back-to-back commands with cmd_valid held high
        clear_stats();
        expect_msg(14'h0500, 3);
        expect_msg(14'h0600, 2);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = 14'h0500;
        bus.cmd_len   = 10'd3;
        acc = -1;
        for (int n = 0; n < 50 && acc < 0; n++) begin
            @(negedge clk);
            if (bus.cmd_ready) acc = cyc;
        end
        check("t6_first_accept", acc >= 0, 1);
        @(posedge clk);
        #1;
        bus.cmd_addr = 14'h0600;
        bus.cmd_len  = 10'd2;
        acc2 = -1;
        for (int n = 0; n < 50 && acc2 < 0; n++) begin
            @(negedge clk);
            if (bus.cmd_ready) acc2 = cyc;
        end
        check("t6_second_accept", acc2 >= 0, 1);
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        wait_done(2);
        check("t6_beats", beats, 5);
        check("t6_second_after_done",
              (done_cyc_q.size() > 0) && (acc2 >= done_cyc_q[0]), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
